// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core and its program controller.
package bf_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TERM  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Opcode bytes understood by the core; a null byte ends the program.
  localparam logic [7:0] OP_INC   = 8'h2B;  // +
  localparam logic [7:0] OP_DEC   = 8'h2D;  // -
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // <
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // >
  localparam logic [7:0] OP_JZ    = 8'h5B;  // [
  localparam logic [7:0] OP_JNZ   = 8'h5D;  // ]
  localparam logic [7:0] OP_OUT   = 8'h2E;  // .
  localparam logic [7:0] OP_IN    = 8'h2C;  // ,
  localparam logic [7:0] OP_NULL  = 8'h00;

  // Consecutive stable cycles on a null byte before the program counts as finished.
  localparam int unsigned HALT_STABLE_CYCLES = 4;
  localparam int unsigned HCNT_W             = 3;

endpackage

// File: rtl/bf_halt_detect.sv
// Detects a core parked on the null terminator: same code address, null byte, several cycles in a row.
module bf_halt_detect
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_CODE = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [ADDR_CODE-1:0] addr,
  input  logic [7:0]           rdata,
  output logic                 halt_c
);

  logic [ADDR_CODE-1:0] prev_addr_q, prev_addr_d;
  logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
  logic                 stable_null;

  // Count stable null cycles; the pulse fires on the cycle the count reaches the threshold.
  always_comb begin
    stable_null = (rdata == OP_NULL) && (addr == prev_addr_q);
    prev_addr_d = addr;
    hcnt_d      = '0;
    halt_c      = 1'b0;
    if (en && stable_null) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
      halt_c = (hcnt_d == HCNT_W'(HALT_STABLE_CYCLES));
    end
  end

  // Previous-address and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr_q <= '0;
      hcnt_q      <= '0;
    end else begin
      prev_addr_q <= prev_addr_d;
      hcnt_q      <= hcnt_d;
    end
  end

endmodule

// File: rtl/bf_program_controller.sv
// Loads a program into code RAM, clears array RAM, runs the core and detects its termination.
module bf_program_controller
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_CODE  = 9,
  parameter int unsigned ADDR_ARRAY = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  run_start,
  input  logic                  abort,
  output logic [ADDR_CODE-1:0]  code_addr,
  output logic [7:0]            code_wdata,
  output logic                  code_we,
  input  logic [7:0]            code_rdata,
  input  logic [ADDR_CODE-1:0]  core_addr_code,
  output logic [7:0]            core_data_code,
  input  logic [ADDR_ARRAY-1:0] core_addr_array,
  input  logic [7:0]            core_dataOut_array,
  input  logic                  core_writeRq_array,
  output logic [ADDR_ARRAY-1:0] array_addr,
  output logic [7:0]            array_wdata,
  output logic                  array_we,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  load_overflow
);

  state_e                state_q, state_d;
  logic [ADDR_CODE-1:0]  wptr_q, wptr_d;
  logic [ADDR_ARRAY-1:0] cptr_q, cptr_d;
  logic                  ovf_q, ovf_d;
  logic                  code_full_c;
  logic                  run_c;
  logic                  halt_c;

  // The last code slot is reserved so the terminator always fits.
  assign code_full_c = (wptr_q == {ADDR_CODE{1'b1}});
  assign run_c       = (state_q == ST_RUN);

  bf_halt_detect #(
    .ADDR_CODE (ADDR_CODE)
  ) u_halt_detect (
    .clk    (clk),
    .reset  (reset),
    .en     (run_c),
    .addr   (core_addr_code),
    .rdata  (code_rdata),
    .halt_c (halt_c)
  );

  // State, pointer and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      cptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cptr_q  <= cptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state plus pointer/overflow updates; abort overrides everything.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cptr_d  = cptr_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          ovf_d   = 1'b0;
        end else if (run_start) begin
          state_d = ST_CLEAR;
          cptr_d  = '0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          if (!code_full_c) wptr_d = wptr_q + ADDR_CODE'(1);
          else              ovf_d  = 1'b1;
          if (load_last)    state_d = ST_TERM;
        end
      end
      ST_TERM:  state_d = ST_IDLE;
      ST_CLEAR: begin
        cptr_d = cptr_q + ADDR_ARRAY'(1);
        if (cptr_q == {ADDR_ARRAY{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_c) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      wptr_d  = wptr_q;
      cptr_d  = cptr_q;
      ovf_d   = ovf_q;
    end
  end

  // RAM port muxes, write enables and status, decoded from the current state.
  always_comb begin
    load_ready     = 1'b0;
    code_addr      = '0;
    code_wdata     = '0;
    code_we        = 1'b0;
    core_data_code = '0;
    array_addr     = '0;
    array_wdata    = '0;
    array_we       = 1'b0;
    core_reset_n   = 1'b0;
    busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done           = (state_q == ST_DONE);
    load_overflow  = ovf_q;
    case (state_q)
      ST_LOAD: begin
        load_ready = !code_full_c;
        code_addr  = wptr_q;
        code_wdata = load_byte;
        code_we    = load_valid && !code_full_c && !abort;
      end
      ST_TERM: begin
        code_addr  = wptr_q;
        code_wdata = OP_NULL;
        code_we    = !abort;
      end
      ST_CLEAR: begin
        array_addr = cptr_q;
        array_we   = !abort;
      end
      ST_RUN: begin
        core_reset_n   = 1'b1;
        code_addr      = core_addr_code;
        core_data_code = code_rdata;
        array_addr     = core_addr_array;
        array_wdata    = core_dataOut_array;
        array_we       = core_writeRq_array && !abort;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bf_program_controller.sv
// Self-checking bench for bf_program_controller with behavioural code/array RAMs and a scripted core.
module tb_bf_program_controller;

  localparam int unsigned CA     = 3;
  localparam int unsigned AA     = 9;
  localparam int          CDEPTH = 1 << CA;
  localparam int          ADEPTH = 1 << AA;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [79:0] bytes;
    int          n;
    logic        exp_ovf;
    int          exp_term;
  } load_vec_t;

  logic          clk = 1'b0;
  logic          reset, load_start, load_valid, load_last, run_start, abort;
  logic [7:0]    load_byte;
  logic          load_ready;
  logic [CA-1:0] code_addr;
  logic [7:0]    code_wdata, code_rdata, core_data_code;
  logic          code_we;
  logic [CA-1:0] core_addr_code;
  logic [AA-1:0] core_addr_array, array_addr;
  logic [7:0]    core_dataOut_array, array_wdata;
  logic          core_writeRq_array, array_we;
  logic          core_reset_n, busy, done, load_overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] code_mem [CDEPTH];
  logic [7:0] arr_mem  [ADEPTH];
  logic       code_fill = 1'b0;
  logic       arr_fill  = 1'b0;

  always #5 clk = ~clk;

  bf_program_controller #(
    .ADDR_CODE  (CA),
    .ADDR_ARRAY (AA)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .load_start         (load_start),
    .load_valid         (load_valid),
    .load_byte          (load_byte),
    .load_last          (load_last),
    .load_ready         (load_ready),
    .run_start          (run_start),
    .abort              (abort),
    .code_addr          (code_addr),
    .code_wdata         (code_wdata),
    .code_we            (code_we),
    .code_rdata         (code_rdata),
    .core_addr_code     (core_addr_code),
    .core_data_code     (core_data_code),
    .core_addr_array    (core_addr_array),
    .core_dataOut_array (core_dataOut_array),
    .core_writeRq_array (core_writeRq_array),
    .array_addr         (array_addr),
    .array_wdata        (array_wdata),
    .array_we           (array_we),
    .core_reset_n       (core_reset_n),
    .busy               (busy),
    .done               (done),
    .load_overflow      (load_overflow)
  );

  // Behavioural RAMs; the fill flags pre-load recognisable garbage.
  always @(posedge clk) begin
    if (code_fill) for (int i = 0; i < CDEPTH; i++) code_mem[i] <= 8'hFF;
    else if (code_we) code_mem[code_addr] <= code_wdata;
    if (arr_fill) for (int i = 0; i < ADEPTH; i++) arr_mem[i] <= 8'(i) | 8'h80;
    else if (array_we) arr_mem[array_addr] <= array_wdata;
  end
  assign code_rdata = code_mem[code_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bq_t to_q(input logic [79:0] b, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(b[8*i +: 8]);
    return q;
  endfunction

  // Stream a program; the model keeps its own count of bytes that fit (depth minus terminator slot).
  task automatic load_prog(input bq_t prog, input bit gaps, output int cycles);
    int n, k, stored, ready_bad, mism;
    n = prog.size(); k = 0; stored = 0; ready_bad = 0; mism = 0; cycles = 0;
    code_fill = 1'b1; step(); code_fill = 1'b0;
    load_start = 1'b1; step(); load_start = 1'b0;
    while (k < n && cycles < 200) begin
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_byte  = prog[k];
      load_last  = (k == n - 1);
      #1;
      if (load_ready !== ((stored < CDEPTH - 1) ? 1'b1 : 1'b0)) ready_bad++;
      if (load_valid) begin
        if (stored < CDEPTH - 1) stored++;
        k++;
      end
      step();
      cycles++;
    end
    load_valid = 1'b0; load_last = 1'b0;
    #1;
    chk("load_done_in_budget", k, n);
    chk("load_ready_track", ready_bad, 0);
    chk("term_we", code_we, 1);
    chk("term_addr", code_addr, stored);
    step(); #1;
    chk("load_back_idle", busy, 0);
    chk("load_overflow", load_overflow, (n > CDEPTH - 1) ? 1 : 0);
    for (int i = 0; i < stored; i++) if (code_mem[i] !== prog[i]) mism++;
    if (code_mem[stored] !== 8'h00) mism++;
    chk("code_image", mism, 0);
  endtask

  // Garbage-fill the array, start a run, and verify the clear sweep up to core release.
  task automatic run_clear();
    int cnt, bad, nz;
    cnt = 0; bad = 0; nz = 0;
    arr_fill = 1'b1; step(); arr_fill = 1'b0;
    run_start = 1'b1; step(); run_start = 1'b0;
    #1;
    while (core_reset_n === 1'b0 && cnt < 600) begin
      if (array_we !== 1'b1 || array_addr !== AA'(cnt)) bad++;
      step(); #1;
      cnt++;
    end
    chk("clear_len", cnt, ADEPTH);
    chk("clear_seq", bad, 0);
    chk("core_released", core_reset_n, 1);
    for (int i = 0; i < ADEPTH; i++) if (arr_mem[i] !== 8'h00) nz++;
    chk("array_zero", nz, 0);
  endtask

  // Park the scripted core on an address holding the terminator and bound the halt latency.
  task automatic park_expect_done(input int addr);
    int c;
    c = 0;
    core_addr_code = CA'(addr);
    while (done !== 1'b1 && c < 20) begin
      step(); #1;
      c++;
    end
    chk("halt_not_early", (c >= 4) ? 1 : 0, 1);
    chk("halt_latency_max", (c <= 6) ? 1 : 0, 1);
    chk("done_core_in_reset", core_reset_n, 0);
    chk("done_not_busy", busy, 0);
  endtask

  initial begin
    load_vec_t tbl [5];
    bq_t       q;
    int        cyc, seen;

    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_byte = '0;
    run_start = 1'b0; abort = 1'b0; core_addr_code = '0; core_addr_array = '0;
    core_dataOut_array = '0; core_writeRq_array = 1'b0;
    code_fill = 1'b1;
    step(); step();
    code_fill = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_overflow", load_overflow, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_code_we", code_we, 0);
    chk("rst_array_we", array_we, 0);
    chk("rst_core_data", core_data_code, 0);
    reset = 1'b0;
    step();

    // Table of load cases: bytes (first byte lowest), count, expected overflow, terminator address.
    tbl[0] = '{80'h2E2B2B2B,            4, 1'b0, 4};
    tbl[1] = '{80'h2B,                  1, 1'b0, 1};
    tbl[2] = '{80'h77665544332211,      7, 1'b0, 7};
    tbl[3] = '{80'h8877665544332211,    8, 1'b1, 7};
    tbl[4] = '{80'h090807060504030201,  9, 1'b1, 7};
    for (int t = 0; t < 5; t++) begin
      load_prog(to_q(tbl[t].bytes, tbl[t].n), 1'b0, cyc);
      chk("tbl_cycles", cyc, tbl[t].n);
      chk("tbl_overflow", load_overflow, tbl[t].exp_ovf);
      chk("tbl_term_zero", code_mem[tbl[t].exp_term], 8'h00);
    end

    // Random programs with random valid gaps.
    for (int r = 0; r < 25; r++) begin
      q = {};
      for (int i = 0, n = $urandom_range(1, 11); i < n; i++) q.push_back(8'($urandom_range(1, 255)));
      load_prog(q, 1'b1, cyc);
    end

    // "+++." : clear, release, code fetch and array pass-through, then halt on the terminator.
    q = to_q(80'h2E2B2B2B, 4);
    load_prog(q, 1'b0, cyc);
    core_addr_code = '0;
    run_clear();
    for (int i = 0; i < 4; i++) begin
      core_addr_code = CA'(i);
      #1;
      chk("run_code_addr", code_addr, i);
      chk("run_code_data", core_data_code, q[i]);
      step();
    end
    core_addr_array = '0; core_dataOut_array = 8'd3; core_writeRq_array = 1'b1;
    #1;
    chk("run_array_we", array_we, 1);
    chk("run_array_wdata", array_wdata, 3);
    step();
    core_writeRq_array = 1'b0;
    #1;
    chk("run_array_mem", arr_mem[0], 3);
    chk("run_not_done", done, 0);
    park_expect_done(4);
    chk("done_core_data_zero", core_data_code, 0);

    // ",." : core blocked on input must not look halted.
    load_prog(to_q(80'h2E2C, 2), 1'b0, cyc);
    core_addr_code = '0;
    run_clear();
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(); #1;
      if (done !== 1'b0 || busy !== 1'b1) seen++;
    end
    chk("blocked_stays_run", seen, 0);
    core_addr_code = CA'(1);
    step();
    park_expect_done(2);

    // "[-]" skip path, then rerun straight from DONE.
    load_prog(to_q(80'h5D2D5B, 3), 1'b0, cyc);
    for (int pass = 0; pass < 2; pass++) begin
      core_addr_code = '0;
      run_clear();
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        core_addr_code = (i < 3) ? CA'(0) : CA'(i - 2);
        step(); #1;
        if (done !== 1'b0) seen++;
      end
      chk("browse_no_halt", seen, 0);
      park_expect_done(3);
    end

    // load_start and run_start together: the load wins.
    load_start = 1'b1; run_start = 1'b1;
    step();
    load_start = 1'b0; run_start = 1'b0;
    #1;
    chk("tie_load_ready", load_ready, 1);
    chk("tie_array_we", array_we, 0);
    load_valid = 1'b1; load_last = 1'b1; load_byte = 8'h2B;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    step(); #1;
    chk("tie_back_idle", busy, 0);

    // Abort mid-clear keeps the overflow flag.
    load_prog(to_q(80'h090807060504030201, 9), 1'b0, cyc);
    run_start = 1'b1; step(); run_start = 1'b0;
    repeat (100) step();
    abort = 1'b1;
    #1;
    chk("abort_array_we", array_we, 0);
    step();
    abort = 1'b0;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_core_reset_n", core_reset_n, 0);
    chk("abort_keeps_ovf", load_overflow, 1);

    // Reset while running.
    core_addr_code = '0;
    run_clear();
    reset = 1'b1;
    step(); #1;
    chk("rrun_busy", busy, 0);
    chk("rrun_core_reset_n", core_reset_n, 0);
    chk("rrun_done", done, 0);
    chk("rrun_overflow", load_overflow, 0);
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
